// File: rtl/dbl_buf_arb.sv
// Round-robin two-requester arbiter that feeds a double buffer, plus a one-entry
// output register that drains the buffer head. Grant counters exist with DBL_BUF_ARB_STATS_EN.
module dbl_buf_arb #(
  parameter int unsigned PKT_WIDTH = 128,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
`ifdef DBL_BUF_ARB_STATS_EN
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1,
`endif
  input  logic                 req0,
  input  logic                 req1,
  input  logic [PKT_WIDTH-1:0] din0,
  input  logic [PKT_WIDTH-1:0] din1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 buf_wr,
  output logic [PKT_WIDTH-1:0] buf_din,
  input  logic                 buf_full,
  input  logic                 buf_vld,
  input  logic [PKT_WIDTH-1:0] buf_dout,
  output logic                 buf_rd,
  output logic                 out_vld,
  output logic [PKT_WIDTH-1:0] out_data,
  input  logic                 out_rdy
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   rr;

  // Grants are gated by rst_l so nothing is accepted while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_l && !buf_full) begin
      gnt0 = req0 && (!req1 || !rr);
      gnt1 = req1 && (!req0 ||  rr);
    end
  end

  assign buf_wr  = gnt0 | gnt1;
  assign buf_din = gnt1 ? din1 : din0;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr <= 1'b0;
    end else if (gnt0) begin
      rr <= 1'b1;
    end else if (gnt1) begin
      rr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_rd    = 1'b0;
    unique case (state)
      EMPTY: begin
        if (buf_vld) begin
          buf_rd    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_rdy) begin
          if (buf_vld) begin
            buf_rd = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (!rst_l) begin
      buf_rd = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state    <= EMPTY;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      if (buf_rd) begin
        out_data <= buf_dout;
      end
    end
  end

  assign out_vld = (state == HOLD);

`ifdef DBL_BUF_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && (cnt0 != '1)) begin
        cnt0 <= cnt0 + CNT_WIDTH'(1);
      end
      if (gnt1 && (cnt1 != '1)) begin
        cnt1 <= cnt1 + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dbl_buf_arb.sv
// Directed self-checking bench for dbl_buf_arb; stats checks run when DBL_BUF_ARB_STATS_EN is defined.
module tb_dbl_buf_arb;
  localparam int unsigned PW = 16;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst_l;
  logic          req0, req1;
  logic [PW-1:0] din0, din1;
  logic          gnt0, gnt1;
  logic          buf_wr;
  logic [PW-1:0] buf_din;
  logic          buf_full, buf_vld;
  logic [PW-1:0] buf_dout;
  logic          buf_rd;
  logic          out_vld;
  logic [PW-1:0] out_data;
  logic          out_rdy;
`ifdef DBL_BUF_ARB_STATS_EN
  logic [CW-1:0] cnt0, cnt1;
`endif

  int checks = 0;
  int errors = 0;

  dbl_buf_arb #(.PKT_WIDTH(PW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_l(rst_l),
`ifdef DBL_BUF_ARB_STATS_EN
    .cnt0(cnt0), .cnt1(cnt1),
`endif
    .req0(req0), .req1(req1), .din0(din0), .din1(din1),
    .gnt0(gnt0), .gnt1(gnt1), .buf_wr(buf_wr), .buf_din(buf_din),
    .buf_full(buf_full), .buf_vld(buf_vld), .buf_dout(buf_dout), .buf_rd(buf_rd),
    .out_vld(out_vld), .out_data(out_data), .out_rdy(out_rdy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_l = 1'b0; req0 = 1'b1; req1 = 1'b1; din0 = 16'h0011; din1 = 16'h0022;
    buf_full = 1'b0; buf_vld = 1'b1; buf_dout = 16'h00EE; out_rdy = 1'b1;
    #2;
    checks++; if ({gnt0, gnt1, buf_wr, buf_rd} !== 4'b0000) begin errors++;
      $display("FAIL reset_strobes got %b exp 0000", {gnt0, gnt1, buf_wr, buf_rd}); end
    tick; tick;
    checks++; if (out_vld !== 1'b0) begin errors++;
      $display("FAIL reset_out_vld got %b exp 0", out_vld); end
    checks++; if (out_data !== 16'h0000) begin errors++;
      $display("FAIL reset_out_data got %h exp 0000", out_data); end
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; buf_vld = 1'b0; out_rdy = 1'b0;
    rst_l = 1'b1;
    tick;
  endtask

  task automatic test_round_robin;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rr_gnt[%0d] got %b exp %b", i, {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      checks++; if (buf_wr !== 1'b1 || buf_din !== ((i % 2 == 0) ? 16'h0011 : 16'h0022)) begin errors++;
        $display("FAIL rr_din[%0d] got wr=%b din=%h", i, buf_wr, buf_din); end
      tick;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_full;
    req1 = 1'b1; buf_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({gnt0, gnt1, buf_wr} !== 3'b000) begin errors++;
        $display("FAIL full_block[%0d] got gnt/wr %b exp 000", i, {gnt0, gnt1, buf_wr}); end
      tick;
    end
    buf_full = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1, buf_wr} !== 3'b011 || buf_din !== 16'h0022) begin errors++;
      $display("FAIL full_release got gnt/wr %b din %h exp 011 0022", {gnt0, gnt1, buf_wr}, buf_din); end
    tick;
    req1 = 1'b0;
  endtask

  task automatic test_stream;
    logic [PW-1:0] pkts [3];
    pkts[0] = 16'h000A; pkts[1] = 16'h000B; pkts[2] = 16'h000C;
    out_rdy = 1'b1; buf_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      buf_dout = pkts[i];
      #1;
      checks++; if (buf_rd !== 1'b1) begin errors++;
        $display("FAIL stream_rd[%0d] got %b exp 1", i, buf_rd); end
      tick;
      checks++; if (out_vld !== 1'b1 || out_data !== pkts[i]) begin errors++;
        $display("FAIL stream_out[%0d] got vld=%b data=%h exp 1 %h", i, out_vld, out_data, pkts[i]); end
    end
    buf_vld = 1'b0;
    #1;
    checks++; if (buf_rd !== 1'b0) begin errors++;
      $display("FAIL stream_idle_rd got %b exp 0", buf_rd); end
    tick;
    checks++; if (out_vld !== 1'b0) begin errors++;
      $display("FAIL stream_drain got out_vld %b exp 0", out_vld); end
  endtask

  task automatic test_hold;
    out_rdy = 1'b0; buf_vld = 1'b1; buf_dout = 16'h0005;
    tick;
    buf_dout = 16'h0009;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (out_vld !== 1'b1 || out_data !== 16'h0005 || buf_rd !== 1'b0) begin errors++;
        $display("FAIL hold[%0d] got vld=%b data=%h rd=%b exp 1 0005 0", i, out_vld, out_data, buf_rd); end
      tick;
    end
    out_rdy = 1'b1;
    #1;
    checks++; if (buf_rd !== 1'b1) begin errors++;
      $display("FAIL hold_release_rd got %b exp 1", buf_rd); end
    tick;
    checks++; if (out_data !== 16'h0009) begin errors++;
      $display("FAIL hold_reload got %h exp 0009", out_data); end
    out_rdy = 1'b0; buf_vld = 1'b0;
  endtask

  task automatic test_reset_mid;
    req0 = 1'b1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++;
      $display("FAIL single_req0 got %b exp 10", {gnt0, gnt1}); end
    tick;
    req0 = 1'b1; req1 = 1'b1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b01) begin errors++;
      $display("FAIL rr_after_gnt0 got %b exp 01", {gnt0, gnt1}); end
    rst_l = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0 || out_data !== 16'h0000) begin errors++;
      $display("FAIL async_reset got vld=%b data=%h exp 0 0000", out_vld, out_data); end
    checks++; if ({gnt0, gnt1, buf_wr} !== 3'b000) begin errors++;
      $display("FAIL reset_gnt got %b exp 000", {gnt0, gnt1, buf_wr}); end
    @(negedge clk);
    rst_l = 1'b1; buf_vld = 1'b1; out_rdy = 1'b0;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++;
      $display("FAIL rr_after_reset got %b exp 10", {gnt0, gnt1}); end
    checks++; if (buf_rd !== 1'b1 || out_vld !== 1'b0) begin errors++;
      $display("FAIL empty_after_reset got rd=%b vld=%b exp 1 0", buf_rd, out_vld); end
    req0 = 1'b0; req1 = 1'b0; buf_vld = 1'b0;
    tick;
  endtask

`ifdef DBL_BUF_ARB_STATS_EN
  task automatic test_stats;
    @(negedge clk); rst_l = 1'b0;
    #1;
    checks++; if (cnt0 !== 2'd0 || cnt1 !== 2'd0) begin errors++;
      $display("FAIL stats_reset got %0d %0d exp 0 0", cnt0, cnt1); end
    @(negedge clk); rst_l = 1'b1;
    tick;
    req0 = 1'b1;
    tick; tick;
    checks++; if (cnt0 !== 2'd2) begin errors++;
      $display("FAIL stats_count got %0d exp 2", cnt0); end
    tick; tick; tick;
    req0 = 1'b0;
    checks++; if (cnt0 !== 2'd3 || cnt1 !== 2'd0) begin errors++;
      $display("FAIL stats_saturate got %0d %0d exp 3 0", cnt0, cnt1); end
  endtask
`endif

  initial begin
    test_reset;
    test_round_robin;
    test_full;
    test_stream;
    test_hold;
    test_reset_mid;
`ifdef DBL_BUF_ARB_STATS_EN
    test_stats;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout reached exp finish");
    $fatal(1);
  end
endmodule
